// File: rtl/sprite_draw_arbiter_if.sv
// Sprite requester bundle and framebuffer pixel-write bus.
// master = game-object side, slave = the arbiter.
interface sprite_draw_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int S_W     = 6,
    parameter int COLOR_W = 3
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*X_W-1:0]     req_x;
    logic [NUM_REQ*Y_W-1:0]     req_y;
    logic [NUM_REQ*S_W-1:0]     req_w;
    logic [NUM_REQ*S_W-1:0]     req_h;
    logic [NUM_REQ*COLOR_W-1:0] req_color;
    logic [NUM_REQ-1:0]         grant;
    logic [NUM_REQ-1:0]         ack;
    logic [X_W-1:0]             pix_x;
    logic [Y_W-1:0]             pix_y;
    logic [COLOR_W-1:0]         pix_color;
    logic                       pix_we;

    modport master (
        output req, req_x, req_y, req_w, req_h, req_color,
        input  grant, ack, pix_x, pix_y, pix_color, pix_we
    );

    modport slave (
        input  req, req_x, req_y, req_w, req_h, req_color,
        output grant, ack, pix_x, pix_y, pix_color, pix_we
    );
endinterface

// File: rtl/sprite_draw_arbiter.sv
// Once-per-frame sprite rectangle rasteriser sharing one framebuffer write port.
// Optional macro ARB_FIXED_PRIO_EN: lowest-index-first instead of round-robin.
module sprite_draw_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int S_W      = 6,
    parameter int COLOR_W  = 3,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic clk,
    input  logic resetn,
    input  logic vblank_start,
    sprite_draw_arbiter_if.slave bus,
    output logic busy,
    output logic overrun
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [X_W:0] H_LIM = (X_W+1)'(H_ACTIVE);
    localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_ACTIVE);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_LOAD, S_DRAW, S_ACK
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   served_q, served_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic [S_W-1:0]       w_q, w_d;
    logic [S_W-1:0]       h_q, h_d;
    logic [COLOR_W-1:0]   col_q, col_d;
    logic [S_W-1:0]       cx_q, cx_d;
    logic [S_W-1:0]       cy_q, cy_d;
    logic [X_W-1:0]       pix_x_q, pix_x_d;
    logic [Y_W-1:0]       pix_y_q, pix_y_d;
    logic [COLOR_W-1:0]   pix_col_q, pix_col_d;
    logic                 pix_we_q, pix_we_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;

    logic [NUM_REQ-1:0]   cand;
    logic                 found;
    logic [IW-1:0]        pick;
    logic [IW:0]          jj;

    logic [X_W-1:0]       ld_x;
    logic [Y_W-1:0]       ld_y;
    logic [S_W-1:0]       ld_w;
    logic [S_W-1:0]       ld_h;
    logic [COLOR_W-1:0]   ld_c;

    logic                 emit;
    logic [X_W-1:0]       ex;
    logic [Y_W-1:0]       ey;
    logic [S_W-1:0]       ecx;
    logic [S_W-1:0]       ecy;
    logic [COLOR_W-1:0]   ecol;
    logic [X_W:0]         sum_x;
    logic [Y_W:0]         sum_y;

    assign ld_x = bus.req_x[owner_q*X_W +: X_W];
    assign ld_y = bus.req_y[owner_q*Y_W +: Y_W];
    assign ld_w = bus.req_w[owner_q*S_W +: S_W];
    assign ld_h = bus.req_h[owner_q*S_W +: S_W];
    assign ld_c = bus.req_color[owner_q*COLOR_W +: COLOR_W];

    // First pending candidate scanning upward from the pointer, wrapping.
    always_comb begin
        cand  = bus.req & ~served_q;
        found = 1'b0;
        pick  = '0;
        jj    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            jj = {1'b0, ptr_q} + (IW+1)'(k);
            if (jj >= (IW+1)'(NUM_REQ)) jj = jj - (IW+1)'(NUM_REQ);
            if (!found && cand[jj[IW-1:0]]) begin
                found = 1'b1;
                pick  = jj[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        served_d  = served_q;
        grant_d   = grant_q;
        ack_d     = '0;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        x_d       = x_q;
        y_d       = y_q;
        w_d       = w_q;
        h_d       = h_q;
        col_d     = col_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        pix_x_d   = pix_x_q;
        pix_y_d   = pix_y_q;
        pix_col_d = pix_col_q;
        pix_we_d  = 1'b0;
        emit      = 1'b0;
        ex        = x_q;
        ey        = y_q;
        ecx       = '0;
        ecy       = '0;
        ecol      = col_q;
        overrun_d = vblank_start && (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (vblank_start) begin
                    served_d = '0;
                    state_d  = S_ARB;
                end
            end
            S_ARB: begin
                if (found) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    owner_d       = pick;
                    state_d       = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                x_d   = ld_x;
                y_d   = ld_y;
                w_d   = ld_w;
                h_d   = ld_h;
                col_d = ld_c;
                cx_d  = '0;
                cy_d  = '0;
                if (ld_w == '0 || ld_h == '0) begin
                    state_d = S_ACK;
                end else begin
                    // Pixel (0,0) is issued straight from the live fields.
                    state_d = S_DRAW;
                    emit    = 1'b1;
                    ex      = ld_x;
                    ey      = ld_y;
                    ecol    = ld_c;
                end
            end
            S_DRAW: begin
                if (cx_q == w_q - 1'b1 && cy_q == h_q - 1'b1) begin
                    state_d = S_ACK;
                end else begin
                    emit = 1'b1;
                    if (cx_q == w_q - 1'b1) begin
                        cx_d = '0;
                        cy_d = cy_q + 1'b1;
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                    ecx = cx_d;
                    ecy = cy_d;
                end
            end
            S_ACK: begin
                ack_d[owner_q]    = 1'b1;
                served_d[owner_q] = 1'b1;
                grant_d           = '0;
`ifdef ARB_FIXED_PRIO_EN
                ptr_d = '0;
`else
                ptr_d = (owner_q == IW'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
`endif
                state_d = S_ARB;
            end
            default: state_d = S_IDLE;
        endcase

        sum_x = {1'b0, ex} + (X_W+1)'(ecx);
        sum_y = {1'b0, ey} + (Y_W+1)'(ecy);
        if (emit && sum_x < H_LIM && sum_y < V_LIM) begin
            pix_we_d  = 1'b1;
            pix_x_d   = sum_x[X_W-1:0];
            pix_y_d   = sum_y[Y_W-1:0];
            pix_col_d = ecol;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            served_q  <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            ptr_q     <= '0;
            owner_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            col_q     <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            pix_col_q <= '0;
            pix_we_q  <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            served_q  <= served_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            x_q       <= x_d;
            y_q       <= y_d;
            w_q       <= w_d;
            h_q       <= h_d;
            col_q     <= col_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            pix_col_q <= pix_col_d;
            pix_we_q  <= pix_we_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.ack       = ack_q;
    assign bus.pix_x     = pix_x_q;
    assign bus.pix_y     = pix_y_q;
    assign bus.pix_color = pix_col_q;
    assign bus.pix_we    = pix_we_q;
    assign busy          = busy_q;
    assign overrun       = overrun_q;
endmodule

// File: doc/sprite_draw_arbiter.md
Name: sprite_draw_arbiter

Overview:
Shares the single framebuffer pixel-write port between NUM_REQ sprite requesters, such as the player ship, bullets and enemies.
- Once per frame, on the vertical-blank pulse from the VGA timing logic, it arbitrates round-robin among pending requesters.
- It captures the granted requester's rectangle and emits one pixel write per cycle in raster order.
- It acknowledges the requester, then moves on to the next one.
- It sits between game-object logic and the framebuffer/VGA output path.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
X_W, 10, x coordinate width
Y_W, 9, y coordinate width
S_W, 6, sprite width/height field width
COLOR_W, 3, pixel colour width
H_ACTIVE, 640, visible columns; writes at x >= H_ACTIVE are suppressed
V_ACTIVE, 480, visible rows; writes at y >= V_ACTIVE are suppressed

Ports:
clk  in  1  pixel/system clock
resetn  in  1  asynchronous, active-low reset
vblank_start  in  1  one-cycle pulse at the start of vertical blanking
req  in  NUM_REQ  per-requester draw request (level)
req_x  in  NUM_REQ*X_W  packed rectangle left edges; requester i occupies bits [i*X_W +: X_W]
req_y  in  NUM_REQ*Y_W  packed top edges
req_w  in  NUM_REQ*S_W  packed widths
req_h  in  NUM_REQ*S_W  packed heights
req_color  in  NUM_REQ*COLOR_W  packed colours
grant  out  NUM_REQ  one-hot; high for the whole service of the owner
ack  out  NUM_REQ  one-cycle pulse when the owner's rectangle is complete
pix_x  out  X_W  write column
pix_y  out  Y_W  write row
pix_color  out  COLOR_W  write colour
pix_we  out  1  write enable
busy  out  1  high whenever state != IDLE
overrun  out  1  one-cycle pulse if vblank_start arrives while busy

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (resetn).
- Reset values: all outputs 0, state IDLE, served mask 0, round-robin pointer 0 (requester 0 has highest priority first).
- Reset mid-operation: asserting resetn low at any time returns to reset values immediately; no further ack is issued.
- States: IDLE, ARB, LOAD, DRAW, ACK.

State transitions:
- IDLE: on vblank_start, clear served mask, go to ARB.
- ARB (1 cycle): candidates = req & ~served.
  - Pick the first candidate at or after the pointer, wrapping modulo NUM_REQ.
  - None: go to IDLE.
  - Else: set grant one-hot, go to LOAD.
- LOAD (1 cycle): latch x, y, w, h, colour of the owner; clear cx = cy = 0.
  - If w == 0 or h == 0, go directly to ACK with no writes.
- DRAW: one pixel per cycle.
  - pix_x = x + cx and pix_y = y + cy, computed at X_W+1 / Y_W+1 bits.
  - pix_we = 1 only if the unclipped sum < H_ACTIVE and < V_ACTIVE. Clipped pixels still consume their cycle.
  - cx increments to w-1, then wraps to 0 and cy increments. After pixel (w-1, h-1), go to ACK.
- ACK (1 cycle): ack[owner] = 1, set served[owner], pointer = owner+1 mod NUM_REQ, grant cleared, go to ARB.

Timing and boundary rules:
- Latency: first pix_we appears 3 cycles after vblank_start (IDLE→ARB→LOAD→DRAW).
- A w×h rectangle occupies exactly w*h DRAW cycles.
- Each requester is served at most once per frame, even if req stays high.
- A req dropping after LOAD does not abort the draw; a req rising during the frame is served if the scan has not finished.
- pix_x/pix_y/pix_color hold their last values when pix_we = 0.
- vblank_start while busy: ignored apart from the overrun pulse; the current pass continues unchanged.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: ARB always picks the lowest-index unserved requester; the pointer is unused and held at 0.
- Undefined: round-robin behaviour as described above.

Test Plan:
- Single rectangle: req=0001, x=10, y=20, w=3, h=2, colour 5, vblank pulse → 6 writes at (10,20)(11,20)(12,20)(10,21)(11,21)(12,21), first write 3 cycles after vblank, then ack[0] one cycle, busy falls.
- Round-robin: all four req held, each 1×1. Frame 1 serves 0,1,2,3; pointer ends at 0. With req=1010 on the next frame, serve order is 1,3. Under ARB_FIXED_PRIO_EN, the order is always ascending.
- Clipping: x=638, y=479, w=4, h=2 → 8 DRAW cycles, pix_we only at (638,479) and (639,479), then ack.
- Zero size: w=0, h=7 → no pix_we, ack 2 cycles after grant.
- Overrun and reset: w=h=63 in progress, second vblank_start → overrun pulse and drawing continues. resetn low mid-DRAW → grant, pix_we and busy go to 0 immediately, no ack.
